alu_share_arbiter: RTL and testbench

//  Shares one Hack ALU datapath (16-bit, zx/nx/zy/ny/f/no control) between N requesters.

---
 rtl/alu_share_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one Hack ALU datapath (zx/nx/zy/ny/f/no) between N requesters.
// A round-robin arbiter picks one valid requester while IDLE. A 3-state
// sequencer (IDLE -> EXEC -> RESP) then computes the op and returns a result
// tagged with the requester id.
//
// Parameters:
//   W    operand/result width
//   N    number of requesters (>= 2)
//   IDW  requester-id width, max(1, clog2(N))
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-high reset
//   req_valid  [N]     per-requester op valid
//   req_ready  [N]     one-hot grant, combinational, only in IDLE
//   req_x      [N*W]   packed x operands, requester i at [i*W +: W]
//   req_y      [N*W]   packed y operands
//   req_ctrl   [N*6]   packed control, per slot {zx,nx,zy,ny,f,no}
//   rsp_valid          result valid
//   rsp_ready          result consumer ready
//   rsp_id     [IDW]   requester that owns rsp_out
//   rsp_out    [W]     ALU result
//   busy               high whenever the sequencer is not IDLE
//   rsp_zr / rsp_ng    zero / negative flags of rsp_out
//                      (only when ALU_ARB_FLAGS_EN is defined)
//
// Optional feature macro: ALU_ARB_FLAGS_EN
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int unsigned W   = 16,
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = (N > 2) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    output logic [N-1:0]     req_ready,
    input  logic [N*W-1:0]   req_x,
    input  logic [N*W-1:0]   req_y,
    input  logic [N*6-1:0]   req_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [W-1:0]     rsp_out,
    output logic             busy
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic             rsp_zr,
    output logic             rsp_ng
`endif
);

    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant;
    logic            any_valid;
    logic            accept;
    logic            rsp_done;

    logic [W-1:0]    x_r;
    logic [W-1:0]    y_r;
    logic [CW-1:0]   ctrl_r;
    logic [IDW-1:0]  g_r;

    logic [W-1:0]    x_arr    [N];
    logic [W-1:0]    y_arr    [N];
    logic [CW-1:0]   ctrl_arr [N];

    logic [W-1:0]    x_z, x_n, y_z, y_n, f_o, alu_o;

    // Unpack the flat request buses into per-requester arrays
    for (genvar i = 0; i < int'(N); i++) begin : g_unpack
        assign x_arr[i]    = req_x[i*W +: W];
        assign y_arr[i]    = req_y[i*W +: W];
        assign ctrl_arr[i] = req_ctrl[i*CW +: CW];
    end

    // Round-robin search starting just after rr_ptr. Iterating from the far
    // end lets the nearest valid index overwrite any earlier hit.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        for (int k = int'(N); k >= 1; k--) begin
            if (req_valid[IDW'((int'(rr_ptr) + k) % int'(N))]) begin
                grant     = IDW'((int'(rr_ptr) + k) % int'(N));
                any_valid = 1'b1;
            end
        end
    end

    // Hack ALU on the latched operands; ctrl_r = {zx,nx,zy,ny,f,no}
    always_comb begin
        x_z   = ctrl_r[5] ? '0 : x_r;
        x_n   = ctrl_r[4] ? ~x_z : x_z;
        y_z   = ctrl_r[3] ? '0 : y_r;
        y_n   = ctrl_r[2] ? ~y_z : y_z;
        f_o   = ctrl_r[1] ? W'(x_n + y_n) : (x_n & y_n);
        alu_o = ctrl_r[0] ? ~f_o : f_o;
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and combinational grant; grant is masked while in reset
    always_comb begin
        state_n   = state;
        req_ready = '0;
        accept    = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && !reset) begin
                    req_ready = N'(1) << grant;
                    accept    = 1'b1;
                    state_n   = EXEC;
                end
            end
            EXEC: begin
                state_n = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand capture, result registers and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r       <= '0;
            y_r       <= '0;
            ctrl_r    <= '0;
            g_r       <= '0;
            rsp_out   <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rr_ptr    <= IDW'(N - 1);
        end else begin
            busy <= (state_n != IDLE);
            if (accept) begin
                x_r    <= x_arr[grant];
                y_r    <= y_arr[grant];
                ctrl_r <= ctrl_arr[grant];
                g_r    <= grant;
            end
            if (state == EXEC) begin
                rsp_out   <= alu_o;
                rsp_id    <= g_r;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= rsp_id;
            end
        end
    end

`ifdef ALU_ARB_FLAGS_EN
    // Flags are captured with rsp_out and held through RESP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_zr <= 1'b0;
            rsp_ng <= 1'b0;
        end else if (state == EXEC) begin
            rsp_zr <= (alu_o == '0);
            rsp_ng <= alu_o[W-1];
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Randomized and directed stimulus for alu_share_arbiter (W=16, N=4) checked
// against a transaction-level reference model: round-robin grant choice,
// arithmetic ALU result, latency and response hold behaviour.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

    localparam int unsigned W   = 16;
    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 2;

    logic             clk;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_x;
    logic [N*W-1:0]   req_y;
    logic [N*6-1:0]   req_ctrl;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W-1:0]     rsp_out;
    logic             busy;
`ifdef ALU_ARB_FLAGS_EN
    logic             rsp_zr;
    logic             rsp_ng;
`endif

    logic [W-1:0]     x_a [N];
    logic [W-1:0]     y_a [N];
    logic [5:0]       c_a [N];

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_ptr;
    bit          m_busy;
    int          m_age;
    int          m_id;
    logic [15:0] m_out;
    int          done_ids[$];

    alu_share_arbiter #(.W(W), .N(N), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ctrl  (req_ctrl),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .busy      (busy)
`ifdef ALU_ARB_FLAGS_EN
        ,
        .rsp_zr    (rsp_zr),
        .rsp_ng    (rsp_ng)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            req_x[i*W +: W]   = x_a[i];
            req_y[i*W +: W]   = y_a[i];
            req_ctrl[i*6 +: 6] = c_a[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Hack ALU described arithmetically on integers
    function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        int unsigned a, b, o;
        a = c[5] ? 0 : 32'(x);
        if (c[4]) a = 65535 - a;
        b = c[3] ? 0 : 32'(y);
        if (c[2]) b = 65535 - b;
        o = c[1] ? (a + b) % 65536 : (a & b);
        if (c[0]) o = 65535 - o;
        return 16'(o);
    endfunction

    task automatic model_reset();
        m_ptr  = int'(N) - 1;
        m_busy = 1'b0;
        m_age  = 0;
        done_ids.delete();
    endtask

    // One cycle of checking; inputs for this cycle are already driven
    task automatic step();
        int g;
        int idx;
        logic [N-1:0] exp_rdy;
        #1;
        if (m_busy) m_age++;
        if (!m_busy) begin
            g = -1;
            for (int k = 1; k <= int'(N); k++) begin
                idx = (m_ptr + k) % int'(N);
                if (g < 0 && req_valid[idx]) g = idx;
            end
            exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            check("busy_idle", 32'(busy), 32'(0));
            check("rsp_valid_idle", 32'(rsp_valid), 32'(0));
            if (g >= 0) begin
                m_busy = 1'b1;
                m_age  = 0;
                m_id   = g;
                m_out  = ref_alu(x_a[g], y_a[g], c_a[g]);
            end
        end else begin
            check("req_ready_busy", 32'(req_ready), 32'(0));
            check("busy", 32'(busy), 32'(1));
            check("rsp_valid", 32'(rsp_valid), 32'(m_age >= 2));
            if (m_age >= 2) begin
                check("rsp_id", 32'(rsp_id), 32'(m_id));
                check("rsp_out", 32'(rsp_out), 32'(m_out));
`ifdef ALU_ARB_FLAGS_EN
                check("rsp_zr", 32'(rsp_zr), 32'(m_out == 16'd0));
                check("rsp_ng", 32'(rsp_ng), 32'(m_out[15]));
`endif
                if (rsp_ready) begin
                    m_busy = 1'b0;
                    m_ptr  = m_id;
                    done_ids.push_back(m_id);
                end
            end
        end
    endtask

    task automatic set_all(input logic [15:0] x, input logic [15:0] y, input logic [5:0] c);
        for (int i = 0; i < int'(N); i++) begin
            x_a[i] = x;
            y_a[i] = y;
            c_a[i] = c;
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 4'hF;
        rsp_ready = 1'b0;
        set_all(16'd0, 16'd0, 6'd0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_id", 32'(rsp_id), 32'(0));
        check("rst_rsp_out", 32'(rsp_out), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_req_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        reset     = 1'b0;
        req_valid = '0;

        // Single requester add: 5 + 3
        @(negedge clk);
        req_valid = 4'b0001;
        x_a[0] = 16'd5; y_a[0] = 16'd3; c_a[0] = 6'b000010;
        rsp_ready = 1'b1;
        step();
        @(negedge clk); req_valid = '0; step();
        @(negedge clk); step();
        check("t2_out", 32'(rsp_out), 32'(8));
        check("t2_id", 32'(rsp_id), 32'(0));
        @(negedge clk); step();

        // Reset while in EXEC drops the op
        @(negedge clk);
        req_valid = 4'b0100;
        step();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstx_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rstx_busy", 32'(busy), 32'(0));
        check("rstx_req_ready", 32'(req_ready), 32'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // All valid, x - y: grants rotate 0,1,2,3,0
        set_all(16'd10, 16'd4, 6'b010011);
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        step();
        check("rstx_first_grant", 32'(req_ready), 32'(1));
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            step();
        end
        check("rr_count", 32'(done_ids.size()), 32'(5));
        if (done_ids.size() >= 5) begin
            check("rr_id0", 32'(done_ids[0]), 32'(0));
            check("rr_id1", 32'(done_ids[1]), 32'(1));
            check("rr_id2", 32'(done_ids[2]), 32'(2));
            check("rr_id3", 32'(done_ids[3]), 32'(3));
            check("rr_id4", 32'(done_ids[4]), 32'(0));
        end

        // Wrap-around add and constant -1 on a lone requester
        @(negedge clk);
        req_valid = 4'b0000;
        step();
        @(negedge clk);
        req_valid = 4'b0100;
        x_a[2] = 16'hFFFF; y_a[2] = 16'd1; c_a[2] = 6'b000010;
        step();
        @(negedge clk); req_valid = '0; step();
        @(negedge clk); step();
        check("wrap_out", 32'(rsp_out), 32'(0));
        @(negedge clk); step();
        @(negedge clk);
        req_valid = 4'b0100;
        c_a[2] = 6'b111010;
        step();
        @(negedge clk); req_valid = '0; step();
        @(negedge clk); step();
        check("neg1_out", 32'(rsp_out), 32'(16'hFFFF));
        @(negedge clk); step();

        // Consumer stalls in RESP while all requesters keep asking
        @(negedge clk);
        req_valid = 4'b0010;
        set_all(16'd7, 16'd9, 6'b000000);
        rsp_ready = 1'b0;
        step();
        @(negedge clk); req_valid = 4'hF; step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x_a[i % 4] = 16'($urandom);
            step();
        end
        @(negedge clk); rsp_ready = 1'b1; req_valid = '0; step();
        @(negedge clk); step();

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            req_valid = N'($urandom);
            for (int i = 0; i < int'(N); i++) begin
                x_a[i] = 16'($urandom);
                y_a[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                c_a[i] = 6'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
